// File: rtl/breakout_pkg.sv
// Shared breakout constants: screen and brick geometry, colours, and the
// brick position lookup used by both the brick field and the ball logic.
package breakout_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int BLOCK_WIDTH  = 80;
  localparam int BLOCK_HEIGHT = 30;
  localparam int NUM_BLOCKS   = 12;

  // Row tops and column left edges, in pixels
  localparam logic [9:0] ROW0_TOP = 10'd40;
  localparam logic [9:0] ROW1_TOP = 10'd90;
  localparam logic [9:0] ROW2_TOP = 10'd140;

  localparam logic [9:0] COL0_LEFT = 10'd40;
  localparam logic [9:0] COL1_LEFT = 10'd160;
  localparam logic [9:0] COL2_LEFT = 10'd280;
  localparam logic [9:0] COL3_LEFT = 10'd400;
  localparam logic [9:0] COL4_LEFT = 10'd520;

  localparam logic [9:0] BLOCK_W10 = 10'(BLOCK_WIDTH);
  localparam logic [9:0] BLOCK_H10 = 10'(BLOCK_HEIGHT);

  // RGB332 colours
  localparam logic [7:0] RGB_BLACK = 8'h00;
  localparam logic [7:0] RGB_RED   = 8'hE0;
  localparam logic [7:0] RGB_WHITE = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } field_state_t;

  // Left edge of brick idx; row 2 only has bricks under columns 1 and 3
  function automatic logic [9:0] brick_left(input logic [3:0] idx);
    logic [9:0] left;
    case (idx)
      4'd0, 4'd5:        left = COL0_LEFT;
      4'd1, 4'd6, 4'd10: left = COL1_LEFT;
      4'd2, 4'd7:        left = COL2_LEFT;
      4'd3, 4'd8, 4'd11: left = COL3_LEFT;
      4'd4, 4'd9:        left = COL4_LEFT;
      default:           left = 10'd0;
    endcase
    return left;
  endfunction

  // Top edge of brick idx
  function automatic logic [9:0] brick_top(input logic [3:0] idx);
    logic [9:0] top;
    if (idx < 4'd5)       top = ROW0_TOP;
    else if (idx < 4'd10) top = ROW1_TOP;
    else                  top = ROW2_TOP;
    return top;
  endfunction

endpackage

// File: rtl/brick_locator.sv
// Combinational pixel-to-brick lookup: reports whether the scan position
// falls inside any brick rectangle and which one.
module brick_locator
  import breakout_pkg::*;
(
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       hit,
  output logic [3:0] idx
);

  // Bricks never overlap, so the first match is the only match
  always_comb begin
    hit = 1'b0;
    idx = 4'd0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (!hit &&
          pixel_x >= brick_left(4'(i)) &&
          pixel_x <  brick_left(4'(i)) + BLOCK_W10 &&
          pixel_y >= brick_top(4'(i)) &&
          pixel_y <  brick_top(4'(i)) + BLOCK_H10) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/brick_field.sv
// Brick map: accepts erase commands from the ball logic, flashes the erased
// brick for a number of frames, tracks a BCD score and the win flag, and
// answers per-pixel brick/colour queries with one cycle of latency.
module brick_field
  import breakout_pkg::*;
#(
  parameter int         NUM_BLOCKS   = 12,
  parameter int         FLASH_FRAMES = 8,
  parameter logic [7:0] BRICK_RGB    = 8'hE0,
  parameter logic [7:0] FLASH_RGB    = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        erase_enable,
  input  logic [5:0]  e_pos,
  input  logic        frame_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  output logic        brick_pixel,
  output logic [7:0]  brick_rgb,
  output logic [11:0] alive_mask,
  output logic [7:0]  score,
  output logic        erase_ack,
  output logic        all_cleared
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  field_state_t     state;
  logic [3:0]       flash_idx;
  logic [CNT_W-1:0] flash_cnt;
  logic             phase;
  logic             accept;

  logic             hit_p0;
  logic [3:0]       idx_p0;
  logic             vld_p0;
  logic             solid_p0;
  logic             flash_on_p0;

  // Two-digit BCD increment; the score is bounded by the brick count
  function automatic logic [7:0] bcd_inc(input logic [7:0] val);
    logic [7:0] res;
    if (val[3:0] == 4'd9) res = {val[7:4] + 4'd1, 4'd0};
    else                  res = {val[7:4], val[3:0] + 4'd1};
    return res;
  endfunction

  // An erase only counts for an in-range brick that is still solid
  always_comb begin
    accept = 1'b0;
    if (erase_enable && e_pos < 6'(NUM_BLOCKS))
      accept = alive_mask[e_pos[3:0]];
  end

  // Stage p0: locate the scan position and classify the brick under it
  brick_locator u_locator (
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .hit     (hit_p0),
    .idx     (idx_p0)
  );

  assign vld_p0      = video_on & hit_p0;
  assign solid_p0    = vld_p0 & alive_mask[idx_p0];
  assign flash_on_p0 = vld_p0 & (state == ST_FLASH) & (flash_idx == idx_p0) & phase;

  // Alive mask, score, ack and win flag bookkeeping plus the flash FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive_mask  <= 12'hFFF;
      score       <= 8'h00;
      erase_ack   <= 1'b0;
      all_cleared <= 1'b0;
      state       <= ST_IDLE;
      flash_idx   <= 4'd0;
      flash_cnt   <= '0;
      phase       <= 1'b0;
    end else begin
      erase_ack   <= accept;
      all_cleared <= (alive_mask == 12'h000) && (state == ST_IDLE);
      if (accept) begin
        alive_mask[e_pos[3:0]] <= 1'b0;
        score                  <= bcd_inc(score);
      end
      // A new accept always (re)starts the flash and masks a same-cycle tick
      if (accept) begin
        state     <= ST_FLASH;
        flash_idx <= e_pos[3:0];
        flash_cnt <= CNT_W'(FLASH_FRAMES);
        phase     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_FLASH: begin
            if (frame_tick) begin
              flash_cnt <= flash_cnt - 1'b1;
              phase     <= ~phase;
              if (flash_cnt == CNT_W'(1)) state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Stage p1: registered pixel answer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brick_pixel <= 1'b0;
      brick_rgb   <= RGB_BLACK;
    end else if (solid_p0) begin
      brick_pixel <= 1'b1;
      brick_rgb   <= BRICK_RGB;
    end else if (flash_on_p0) begin
      brick_pixel <= 1'b1;
      brick_rgb   <= FLASH_RGB;
    end else begin
      brick_pixel <= 1'b0;
      brick_rgb   <= RGB_BLACK;
    end
  end

endmodule

// File: doc/brick_field.md
Name: brick_field

Overview:
- Owns the 12-brick map, which is the consumer end of the ball's erase interface (erase_enable/e_pos).
- Accepts erase commands, runs a short flash-out animation on the erased brick, and keeps the alive mask, a BCD score and the win flag.
- Answers per-pixel "brick here / what colour" queries from the VGA scan path with one cycle of latency.
- Sits between the ball logic and the VGA colour mux.

Parameters:
- NUM_BLOCKS, 12, number of bricks; e_pos values >= NUM_BLOCKS are ignored.
- FLASH_FRAMES, 8, frame_tick pulses a brick flashes before it disappears.
- BRICK_RGB, 8'hE0, RGB332 colour of a live brick.
- FLASH_RGB, 8'hFF, RGB332 colour used on flash-on frames.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- erase_enable  in  1  one-cycle erase request from the ball logic
- e_pos  in  6  index of the brick to erase, valid while erase_enable=1
- frame_tick  in  1  one-cycle pulse once per frame (start of vblank)
- pixel_x  in  10  current scan column
- pixel_y  in  10  current scan row
- video_on  in  1  visible-area qualifier for pixel_x/pixel_y
- brick_pixel  out  1  a drawn brick covers the previous cycle's pixel
- brick_rgb  out  8  colour for that pixel, 0 when brick_pixel=0
- alive_mask  out  12  bit i=1 means brick i is still solid (alive, not flashing)
- score  out  8  two BCD digits, count of accepted erases
- erase_ack  out  1  pulses one cycle after an erase is accepted
- all_cleared  out  1  no brick is alive or flashing

Behaviour:
- Reset (async, active-high): alive_mask=12'hFFF, FSM=IDLE, flash counter=0, phase=0, score=8'h00, erase_ack=0, brick_pixel=0, brick_rgb=0, all_cleared=0. Reset asserted mid-flash restores the full wall immediately.
- Brick geometry, 80x30 each, left edge inclusive, right/bottom exclusive:
  - Row 0: bricks 0-4, y 40..69, x left edges 40, 160, 280, 400, 520.
  - Row 1: bricks 5-9, y 90..119, same x left edges.
  - Row 2: brick 10 at x 160, brick 11 at x 400, y 140..169.
- Accepting an erase:
  - Accepted when erase_enable=1, e_pos < NUM_BLOCKS and alive_mask[e_pos]=1.
  - Otherwise ignored: no score change, no ack. This covers duplicates, bricks already flashing or dead, and out-of-range indices.
  - On accept: alive_mask[e_pos] clears on the next edge; score += 1 in BCD (9 -> 10 is 8'h09 -> 8'h10); erase_ack=1 for exactly one cycle.
- FSM:
  - IDLE --accept--> FLASH: flash_idx=e_pos, counter=FLASH_FRAMES, phase=1.
  - FLASH --frame_tick--> counter-1 and phase toggles.
  - FLASH, counter reaches 0 on a tick --> IDLE; the brick is no longer drawn.
  - FLASH --accept of another brick--> old brick drops to dead at once; FLASH restarts on the new index with counter=FLASH_FRAMES, phase=1.
  - An accept and a frame_tick in the same cycle: the accept wins and the tick is not applied to the new flash.
- all_cleared is registered: 1 when alive_mask==0 and FSM==IDLE.
- Pixel path, registered, latency 1:
  - If video_on=1 and the pixel lies inside brick i, and brick i is alive: brick_pixel=1, brick_rgb=BRICK_RGB.
  - If brick i is flash_idx in FLASH with phase=1: brick_pixel=1, brick_rgb=FLASH_RGB.
  - If brick i is flash_idx in FLASH with phase=0: brick_pixel=0, brick_rgb=0.
  - In every other case: brick_pixel=0, brick_rgb=0.
- Widths: pixel comparisons are unsigned 10-bit; the score never exceeds 8'h12, so no BCD wrap is required.

Decomposition:
- breakout_pkg:
  - SCREEN_W=640, SCREEN_H=480, BLOCK_WIDTH=80, BLOCK_HEIGHT=30.
  - Row tops 40/90/140 and the x left-edge table.
  - NUM_BLOCKS, RGB332 colour constants.
  - A brick_left(idx)/brick_top(idx) lookup, shared with the ball logic.
- Sub-module brick_locator (combinational): pixel_x, pixel_y -> hit flag + 4-bit brick index.
- brick_field registers the locator result together with the state lookup.

Test Plan:
- Reset, then scan pixel (50,45) with video_on=1 -> next cycle brick_pixel=1, brick_rgb=8'hE0; alive_mask=12'hFFF, score=8'h00.
- erase_enable=1 with e_pos=3 for one cycle -> alive_mask=12'hFF7, score=8'h01, single erase_ack pulse; pixel (410,50) alternates 8'hFF and nothing across frame_ticks; after 8 ticks brick_pixel=0 there permanently.
- erase e_pos=3 twice in a row, then e_pos=13 -> score stays 8'h01, exactly one ack, alive_mask unchanged by the repeats.
- erase 5, then erase 6 two ticks later -> brick 5 undrawn immediately, brick 6 flashes the full 8 ticks; score=8'h02.
- erase all 12 bricks (10 of them in the same cycle as a frame_tick) -> score=8'h12; all_cleared=1 only after the last flash expires.
- Assert reset during a flash -> alive_mask=12'hFFF and score=8'h00 asynchronously; the brick is drawn solid on the next scan.
